hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter STAGES, 3, number of tracked stages after D (stage 1 = E ... STAGES = W); legal range 2..6.
REQ-003 Parameter T_W, 4, width of Tuse/Tnew fields.
REQ-004 Parameter SEL_W, $clog2(STAGES+1), width of forward-select outputs.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-low reset.
REQ-007 d_valid  input  1  D holds a real instruction; 0 means bubble.
REQ-008 d_rs, d_rt  input  5 each  D source register numbers.
REQ-009 d_rs_tuse, d_rt_tuse  input  T_W each  cycles until operand is needed; 7 = not used.
REQ-010 d_a3 / d_we / d_tnew  input  5 / 1 / T_W  D destination, write enable, Tnew counted from D.
REQ-011 d_mdu_use / d_mdu_start  input  1 each  D reads HI/LO or issues an MDU op / D starts an MDU op.
REQ-012 mdu_busy  input  1  MDU is executing a multi-cycle op.
REQ-013 flush  input  1  exception/eret entry; kill all tracked entries.
REQ-014 stall  output  1  hold F/D, insert bubble into stage 1.
REQ-015 fwd_rs_sel, fwd_rt_sel  output  SEL_W each  0 = GRF value, k = forward from stage k.

Function
REQ-016 Each stage k SHALL hold one entry {valid, a3, we, tnew} in registers.
REQ-017 Every cycle, entries SHALL advance k -> k+1; stage STAGES entry is discarded; stalls never freeze stages 1..STAGES.
REQ-018 On advance, tnew SHALL decrement, saturating at 0; stage 1 loads sat_dec(d_tnew).
REQ-019 Stage 1 SHALL load {d_valid & ~stall, d_a3, d_we, d_tnew}; a stalled or invalid D yields a bubble (valid=0).
REQ-020 An entry matches operand r when valid & we & a3 == r & r != 0; only the youngest matching stage (smallest k) is considered.
REQ-021 Register stall SHALL assert combinationally when, for rs or rt with d_valid, youngest match tnew > operand tuse.
REQ-022 fwd_*_sel SHALL equal the youngest match index when its tnew == 0, else 0.
REQ-023 No match, r == 0, or tuse == 7 SHALL give sel 0 and no stall contribution.
REQ-024 flush SHALL clear every stage valid at the next edge and force stage 1 to bubble; flush with stall in the same cycle: flush wins.
REQ-025 Entries older than stage 1 SHALL be unaffected by d_* values during a stall.

Reset
REQ-026 While reset == 0 at an edge, all stage valid, a3, we, tnew SHALL clear to 0.
REQ-027 After reset, stall = 0 and fwd_rs_sel = fwd_rt_sel = 0 until a matching entry exists; reset mid-stall cancels the stall next cycle.

Configuration
REQ-028 Macro HAZARD_MDU_STALL_EN defined: stall SHALL also assert when d_valid & d_mdu_use & (mdu_busy | d_mdu_start pending in stage 1, tracked by a 1-bit registered flag cleared by flush/reset).
REQ-029 Macro undefined: d_mdu_use, d_mdu_start, mdu_busy SHALL be ignored and the flag not synthesised.

Structure
REQ-030 Package hazard_pkg SHALL hold the entry typedef, TUSE_NONE = 7 constant and the saturating-decrement function.
REQ-031 Sub-module hazard_match SHALL compute youngest match, per-operand stall and select; instantiated once for rs, once for rt.

Verification
REQ-032 lw $8 (tnew 3) then add $9,$8,$8 (tuse 1) -> stall high 1 cycle, then fwd_rs_sel = fwd_rt_sel = 3 no earlier than lw reaching stage 3.
REQ-033 ori $5 (tnew 2) then beq $5,$5 (tuse 0) -> stall 1 cycle, next cycle fwd_rs_sel = 2.
REQ-034 Writes to $0 with tnew 3 then add reading $0 -> stall 0, sel 0.
REQ-035 addi $4 in stage 1 and lw $4 in stage 2, reader tuse 1 -> youngest (stage 1) governs.
REQ-036 Pending lw $8, flush asserted same cycle as stall -> next cycle all valid 0, stall 0.
REQ-037 With HAZARD_MDU_STALL_EN, mult then mflo, mdu_busy high 5 cycles -> stall high until busy low; without macro -> stall 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
// Tracked entries carry a fixed-width tnew field. Narrower Tuse/Tnew inputs
// are zero-extended into this field, so T_W must not exceed TNEW_W.
package hazard_pkg;

    localparam int          TNEW_W    = 8;
    localparam int unsigned TUSE_NONE = 7;   // operand is not read by this instruction

    typedef struct packed {
        logic              valid;
        logic [4:0]        a3;
        logic              we;
        logic [TNEW_W-1:0] tnew;
    } entry_t;

    // One cycle closer to the result being produced, never below zero.
    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand hazard check: finds the youngest tracked stage that writes the
// operand, raises a stall when that result arrives too late, and selects the
// forwarding stage once the result is ready.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int T_W    = 4,
    parameter int SEL_W  = $clog2(STAGES + 1)
) (
    input  logic                 d_valid_i,
    input  logic [4:0]           r_i,
    input  logic [T_W-1:0]       tuse_i,
    input  entry_t [STAGES:1]    stage_i,
    output logic                 stall_o,
    output logic [SEL_W-1:0]     sel_o
);

    logic [STAGES:1]   hit;
    logic              found;
    logic [SEL_W-1:0]  idx;
    logic [TNEW_W-1:0] tnew;
    logic              used;

    genvar gi;
    generate
        for (gi = 1; gi <= STAGES; gi++) begin : g_hit
            assign hit[gi] = stage_i[gi].valid & stage_i[gi].we &
                             (stage_i[gi].a3 == r_i) & (r_i != 5'd0);
        end
    endgenerate

    // Priority pick: scanning oldest to youngest lets the smallest k win.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        tnew  = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (hit[k]) begin
                found = 1'b1;
                idx   = SEL_W'(k);
                tnew  = stage_i[k].tnew;
            end
        end
    end

    assign used    = (tuse_i != T_W'(TUSE_NONE));
    assign stall_o = d_valid_i & used & found & (tnew > TNEW_W'(tuse_i));
    assign sel_o   = (used & found & (tnew == '0)) ? idx : '0;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard for the stages after decode.
// Each stage holds {valid, a3, we, tnew}; entries advance every cycle and
// stalls only inject a bubble into stage 1. Two hazard_match instances
// produce the rs/rt stall terms and forward selects.
// Optional feature: define HAZARD_MDU_STALL_EN to also stall HI/LO users
// while the multiply/divide unit is busy or a start sits in stage 1.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int T_W    = 4,
    parameter int SEL_W  = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [T_W-1:0]   d_rs_tuse,
    input  logic [T_W-1:0]   d_rt_tuse,
    input  logic [4:0]       d_a3,
    input  logic             d_we,
    input  logic [T_W-1:0]   d_tnew,
    input  logic             d_mdu_use,
    input  logic             d_mdu_start,
    input  logic             mdu_busy,
    input  logic             flush,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_rs_sel,
    output logic [SEL_W-1:0] fwd_rt_sel
);

    entry_t [STAGES:1] stage_q;
    entry_t [STAGES:1] stage_d;
    logic              stall_rs;
    logic              stall_rt;
    logic              mdu_stall;

    hazard_match #(.STAGES(STAGES), .T_W(T_W), .SEL_W(SEL_W)) u_match_rs (
        .d_valid_i (d_valid),
        .r_i       (d_rs),
        .tuse_i    (d_rs_tuse),
        .stage_i   (stage_q),
        .stall_o   (stall_rs),
        .sel_o     (fwd_rs_sel)
    );

    hazard_match #(.STAGES(STAGES), .T_W(T_W), .SEL_W(SEL_W)) u_match_rt (
        .d_valid_i (d_valid),
        .r_i       (d_rt),
        .tuse_i    (d_rt_tuse),
        .stage_i   (stage_q),
        .stall_o   (stall_rt),
        .sel_o     (fwd_rt_sel)
    );

`ifdef HAZARD_MDU_STALL_EN
    logic mdu_pend_q;
    logic mdu_pend_d;

    // Remember an MDU start that has just entered stage 1 but has not yet raised busy.
    always_comb begin
        mdu_pend_d = d_valid & ~stall & ~flush & d_mdu_start;
    end

    // Pending-start flag register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mdu_pend_q <= 1'b0;
        end else begin
            mdu_pend_q <= mdu_pend_d;
        end
    end

    assign mdu_stall = d_valid & d_mdu_use & (mdu_busy | mdu_pend_q);
`else
    logic unused_mdu;
    assign unused_mdu = ^{d_mdu_use, d_mdu_start, mdu_busy};
    assign mdu_stall  = 1'b0;
`endif

    assign stall = stall_rs | stall_rt | mdu_stall;

    // Advance all stages; stage 1 takes D or a bubble, flush kills everything.
    always_comb begin
        stage_d          = '0;
        stage_d[1].valid = d_valid & ~stall & ~flush;
        stage_d[1].a3    = d_a3;
        stage_d[1].we    = d_we;
        stage_d[1].tnew  = sat_dec(TNEW_W'(d_tnew));
        for (int k = 2; k <= STAGES; k++) begin
            stage_d[k]       = stage_q[k-1];
            stage_d[k].tnew  = sat_dec(stage_q[k-1].tnew);
            stage_d[k].valid = stage_q[k-1].valid & ~flush;
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed pipeline scenarios followed by
// randomized traffic, checked every cycle against a model that tracks each
// accepted instruction by its issue cycle and the cycle its result is ready.
module tb_hazard_scoreboard;

    localparam int STAGES = 3;
    localparam int T_W    = 4;
    localparam int SEL_W  = $clog2(STAGES + 1);
`ifdef HAZARD_MDU_STALL_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             d_valid;
    logic [4:0]       d_rs, d_rt, d_a3;
    logic [T_W-1:0]   d_rs_tuse, d_rt_tuse, d_tnew;
    logic             d_we, d_mdu_use, d_mdu_start, mdu_busy, flush;
    logic             stall;
    logic [SEL_W-1:0] fwd_rs_sel, fwd_rt_sel;

    hazard_scoreboard #(.STAGES(STAGES), .T_W(T_W), .SEL_W(SEL_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .d_valid     (d_valid),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_rs_tuse   (d_rs_tuse),
        .d_rt_tuse   (d_rt_tuse),
        .d_a3        (d_a3),
        .d_we        (d_we),
        .d_tnew      (d_tnew),
        .d_mdu_use   (d_mdu_use),
        .d_mdu_start (d_mdu_start),
        .mdu_busy    (mdu_busy),
        .flush       (flush),
        .stall       (stall),
        .fwd_rs_sel  (fwd_rs_sel),
        .fwd_rt_sel  (fwd_rt_sel)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    bit known  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    // An accepted instruction issued (left D) at cycle 'issue' sits in stage
    // cyc-issue and has its result ready at cycle 'ready' = issue + d_tnew.
    typedef struct {
        int         issue;
        logic [4:0] a3;
        bit         we;
        int         ready;
    } rec_t;
    rec_t q[$];
    bit   m_pend = 1'b0;

    function automatic void model_op(input logic [4:0] r, input int tuse,
                                     output bit st, output int sel);
        int best = 0;
        int bt   = 0;
        st  = 1'b0;
        sel = 0;
        foreach (q[i]) begin
            int stg = cyc - q[i].issue;
            if (q[i].we && r != 0 && q[i].a3 == r && stg >= 1 && stg <= STAGES &&
                (best == 0 || stg < best)) begin
                best = stg;
                bt   = q[i].ready - cyc;
                if (bt < 0) bt = 0;
            end
        end
        if (tuse == 7 || best == 0) return;
        st  = d_valid && (bt > tuse);
        sel = (bt == 0) ? best : 0;
    endfunction

    function automatic void model_out(output bit st, output int rs_sel, output int rt_sel);
        bit a, b;
        model_op(d_rs, int'(d_rs_tuse), a, rs_sel);
        model_op(d_rt, int'(d_rt_tuse), b, rt_sel);
        st = a || b || (MDU_EN && d_valid && d_mdu_use && (mdu_busy || m_pend));
    endfunction

    always @(posedge clk) begin
        bit s;
        int a, b;
        model_out(s, a, b);
        if (!reset) begin
            q.delete();
            m_pend = 1'b0;
            known  = 1'b1;
        end else begin
            if (flush) q.delete();
            else if (d_valid && !s) q.push_back('{cyc, d_a3, d_we, cyc + int'(d_tnew)});
            m_pend = !flush && d_valid && !s && d_mdu_start;
        end
        cyc++;
        while (q.size() > 0 && cyc - q[0].issue > STAGES) void'(q.pop_front());
    end

    always @(negedge clk) begin
        bit s;
        int a, b;
        if (known) begin
            model_out(s, a, b);
            chk("stall", int'(stall), int'(s));
            chk("fwd_rs_sel", int'(fwd_rs_sel), a);
            chk("fwd_rt_sel", int'(fwd_rt_sel), b);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input int rs, input int rt, input int rsu, input int rtu,
                       input int a3, input bit we, input int tn);
        d_valid   = v;
        d_rs      = 5'(rs);
        d_rt      = 5'(rt);
        d_rs_tuse = T_W'(rsu);
        d_rt_tuse = T_W'(rtu);
        d_a3      = 5'(a3);
        d_we      = we;
        d_tnew    = T_W'(tn);
    endtask

    task automatic idle_drain();
        drv(0, 0, 0, 7, 7, 0, 0, 0);
        d_mdu_use = 0; d_mdu_start = 0; mdu_busy = 0; flush = 0;
        repeat (STAGES + 1) tick();
    endtask

    int tuse_tab[5] = '{0, 1, 2, 3, 7};

    initial begin
        reset = 0; flush = 0; d_mdu_use = 0; d_mdu_start = 0; mdu_busy = 0;
        drv(0, 0, 0, 7, 7, 0, 0, 0);
        repeat (2) tick();
        reset = 1;
        @(negedge clk);
        chk("reset_stall", int'(stall), 0);
        chk("reset_rs_sel", int'(fwd_rs_sel), 0);
        chk("reset_rt_sel", int'(fwd_rt_sel), 0);

        // lw $8 (tnew 3) then add $9,$8,$8 (tuse 1)
        tick(); drv(1, 0, 0, 7, 7, 8, 1, 3);
        tick(); drv(1, 8, 8, 1, 1, 9, 1, 1);
        @(negedge clk); chk("lw_add_stall", int'(stall), 1);
        tick();
        @(negedge clk); chk("lw_add_release", int'(stall), 0);
        chk("lw_add_sel_early", int'(fwd_rs_sel), 0);
        tick(); drv(1, 8, 8, 1, 1, 0, 0, 0);
        @(negedge clk); chk("lw_fwd_rs", int'(fwd_rs_sel), 3);
        chk("lw_fwd_rt", int'(fwd_rt_sel), 3);
        tick(); idle_drain();

        // ori $5 (tnew 2) then beq $5,$5 (tuse 0)
        drv(1, 0, 0, 7, 7, 5, 1, 2);
        tick(); drv(1, 5, 5, 0, 0, 0, 0, 0);
        @(negedge clk); chk("ori_beq_stall", int'(stall), 1);
        tick();
        @(negedge clk); chk("ori_beq_release", int'(stall), 0);
        chk("ori_beq_fwd_rs", int'(fwd_rs_sel), 2);
        tick(); idle_drain();

        // write $0 then read $0
        drv(1, 0, 0, 7, 7, 0, 1, 3);
        tick(); drv(1, 0, 0, 1, 1, 9, 1, 1);
        @(negedge clk); chk("zero_reg_stall", int'(stall), 0);
        chk("zero_reg_sel", int'(fwd_rs_sel), 0);
        tick(); idle_drain();

        // lw $4 (tnew 4), addi $4 (tnew 1), reader of $4 tuse 1
        drv(1, 0, 0, 7, 7, 4, 1, 4);
        tick(); drv(1, 1, 1, 1, 7, 4, 1, 1);
        tick(); drv(1, 4, 4, 1, 1, 0, 0, 0);
        @(negedge clk); chk("youngest_stall", int'(stall), 0);
        chk("youngest_sel", int'(fwd_rs_sel), 1);
        tick(); idle_drain();

        // flush in the same cycle as a load-use stall
        drv(1, 0, 0, 7, 7, 8, 1, 3);
        tick(); drv(1, 8, 8, 1, 1, 9, 1, 1); flush = 1;
        @(negedge clk); chk("flush_cycle_stall", int'(stall), 1);
        tick(); flush = 0;
        @(negedge clk); chk("post_flush_stall", int'(stall), 0);
        chk("post_flush_sel", int'(fwd_rs_sel), 0);
        tick(); idle_drain();

        // mult then mflo with the MDU busy for 5 cycles
        drv(1, 0, 0, 7, 7, 0, 0, 0); d_mdu_use = 1; d_mdu_start = 1;
        tick(); drv(1, 0, 0, 7, 7, 2, 1, 2); d_mdu_start = 0; mdu_busy = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("mdu_busy_stall", int'(stall), int'(MDU_EN));
            tick();
        end
        mdu_busy = 0;
        @(negedge clk); chk("mdu_done_stall", int'(stall), 0);
        tick(); idle_drain();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            d_valid     = ($urandom_range(0, 3) != 0);
            d_rs        = 5'($urandom_range(0, 3));
            d_rt        = 5'($urandom_range(0, 3));
            d_rs_tuse   = T_W'(tuse_tab[$urandom_range(0, 4)]);
            d_rt_tuse   = T_W'(tuse_tab[$urandom_range(0, 4)]);
            d_a3        = 5'($urandom_range(0, 3));
            d_we        = ($urandom_range(0, 3) != 0);
            d_tnew      = T_W'($urandom_range(0, 5));
            d_mdu_use   = ($urandom_range(0, 3) == 0);
            d_mdu_start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 5) == 0) mdu_busy = ~mdu_busy;
            flush       = ($urandom_range(0, 29) == 0);
            reset       = ($urandom_range(0, 199) != 0);
            tick();
        end
        reset = 1;
        idle_drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
